// File: rtl/ap_ctrl_init_pkg.sv
// ---------------------------------------------------------------------------
// ap_ctrl_init_pkg
//   Shared types and default widths for the ap_ctrl_hs / ap_ctrl_chain
//   initiator (ap_ctrl_initiator) and its timestamp FIFO (ap_ctrl_ts_fifo).
//   No ports; imported with "import ap_ctrl_init_pkg::*".
// ---------------------------------------------------------------------------
package ap_ctrl_init_pkg;

  // Default widths / depth used as parameter defaults by the top.
  localparam int CNT_W_DEF = 16;
  localparam int TS_W_DEF  = 32;
  localparam int DEPTH_DEF = 4;

  // Batch controller states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Timestamp / latency type at the default width.
  typedef logic [TS_W_DEF-1:0] ts_t;

endpackage : ap_ctrl_init_pkg

// File: rtl/ap_ctrl_ts_fifo.sv
// ---------------------------------------------------------------------------
// ap_ctrl_ts_fifo
//   DEPTH x TS_W FIFO holding the cycle-counter value captured at each
//   accepted ap_start. Push and pop may occur in the same cycle. Occupancy
//   is tracked by the owner (its outstanding counter), so no full/empty
//   flags are produced; the owner never pushes when full or pops when empty.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   synchronous active-low reset (pointers only)
//     push       in   write push_data at the tail
//     push_data  in   TS_W timestamp to store
//     pop        in   advance the head
//     pop_data   out  TS_W timestamp at the head (valid while non-empty)
// ---------------------------------------------------------------------------
module ap_ctrl_ts_fifo
  import ap_ctrl_init_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [TS_W-1:0] push_data,
  input  logic            pop,
  output logic [TS_W-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage carries no reset; stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule : ap_ctrl_ts_fifo

// File: rtl/ap_ctrl_initiator.sv
// ---------------------------------------------------------------------------
// ap_ctrl_initiator
//   Initiator side of the ap_ctrl_hs / ap_ctrl_chain block-level handshake.
//   Accepts a batch request, issues ap_start for req_count invocations with
//   up to DEPTH in flight, consumes each ap_done and returns one response
//   per invocation carrying its start-to-done latency in cycles.
//
//   Optional feature macro: AP_CTRL_INIT_LAT_EN
//     defined   -> free-running cycle counter and timestamp FIFO are built,
//                  rsp_latency = cycles from start acceptance to done.
//     undefined -> counter and FIFO omitted, rsp_latency tied to 0.
//
//   Ports:
//     ap_clk        in   clock, rising edge
//     ap_rst_n      in   synchronous active-low reset
//     req_valid     in   batch request valid
//     req_ready     out  high only while IDLE
//     req_count     in   CNT_W invocations in the batch
//     ap_start      out  kernel start (register-decoded)
//     ap_ready      in   kernel accepted the start
//     ap_done       in   kernel completed one invocation
//     ap_continue   out  completion consumed (combinational from rsp_ready)
//     rsp_valid     out  response valid
//     rsp_ready     in   response sink ready
//     rsp_latency   out  TS_W latency of the invocation
//     rsp_index     out  CNT_W invocation number within the batch
//     batch_done    out  one-cycle pulse when the batch completes
//     err_spurious  out  sticky: ap_done seen with nothing outstanding
// ---------------------------------------------------------------------------
module ap_ctrl_initiator
  import ap_ctrl_init_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TS_W-1:0]  rsp_latency,
  output logic [CNT_W-1:0] rsp_index,
  output logic             batch_done,
  output logic             err_spurious
);

  // Outstanding counter must hold the value DEPTH itself.
  localparam int OW = $clog2(DEPTH) + 1;

  state_t           state_q,       state_d;
  logic [CNT_W-1:0] starts_left_q, starts_left_d;
  logic [OW-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0] done_cnt_q,    done_cnt_d;
  logic             rsp_valid_q,   rsp_valid_d;
  logic [TS_W-1:0]  rsp_latency_q, rsp_latency_d;
  logic [CNT_W-1:0] rsp_index_q,   rsp_index_d;
  logic             batch_done_q,  batch_done_d;
  logic             err_q,         err_d;

  logic             start_acc;
  logic             cpl;
  logic             spur;
  logic [TS_W-1:0]  lat_val;

  // ap_start depends only on registers so the kernel never sees a
  // combinational path from our inputs to its start.
  assign ap_start    = (state_q == RUN) && (starts_left_q != '0) &&
                       (outstanding_q < OW'(DEPTH));
  // A done is consumed only when the response register can take it.
  assign ap_continue = !rsp_valid_q || rsp_ready;

  assign start_acc   = ap_start && ap_ready;
  assign cpl         = ap_done && ap_continue && (outstanding_q != '0);
  // A done with nothing in flight is an error, even if a start is being
  // accepted in the same cycle (that invocation cannot have finished yet).
  assign spur        = ap_done && (outstanding_q == '0);

`ifdef AP_CTRL_INIT_LAT_EN
  logic [TS_W-1:0] cyc_q;
  logic [TS_W-1:0] ts_pop;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) cyc_q <= '0;
    else           cyc_q <= cyc_q + TS_W'(1);
  end

  ap_ctrl_ts_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_ts_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (start_acc),
    .push_data (cyc_q),
    .pop       (cpl),
    .pop_data  (ts_pop)
  );

  // Modular subtraction keeps the result correct across counter wrap.
  assign lat_val = cyc_q - ts_pop;
`else
  assign lat_val = '0;
`endif

  always_comb begin
    state_d       = state_q;
    starts_left_d = starts_left_q;
    outstanding_d = outstanding_q;
    done_cnt_d    = done_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_latency_d = rsp_latency_q;
    rsp_index_d   = rsp_index_q;
    batch_done_d  = 1'b0;
    err_d         = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_count == '0) begin
            // Empty batch: acknowledge immediately without running.
            batch_done_d = 1'b1;
          end else begin
            starts_left_d = req_count;
            done_cnt_d    = '0;
            err_d         = 1'b0;
            state_d       = RUN;
          end
        end
      end
      RUN: begin
        if (start_acc) starts_left_d = starts_left_q - CNT_W'(1);
        unique case ({start_acc, cpl})
          2'b10:   outstanding_d = outstanding_q + OW'(1);
          2'b01:   outstanding_d = outstanding_q - OW'(1);
          default: outstanding_d = outstanding_q;
        endcase
        // End of batch is judged on the updated counts; the final response
        // may still be waiting in the response register.
        if ((starts_left_d == '0) && (outstanding_d == '0)) begin
          batch_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completions only occur in RUN (outstanding is zero in IDLE).
    if (cpl) begin
      rsp_valid_d   = 1'b1;
      rsp_latency_d = lat_val;
      rsp_index_d   = done_cnt_q;
      done_cnt_d    = done_cnt_q + CNT_W'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end

    if (spur) err_d = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q       <= IDLE;
      starts_left_q <= '0;
      outstanding_q <= '0;
      done_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_latency_q <= '0;
      rsp_index_q   <= '0;
      batch_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      starts_left_q <= starts_left_d;
      outstanding_q <= outstanding_d;
      done_cnt_q    <= done_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_latency_q <= rsp_latency_d;
      rsp_index_q   <= rsp_index_d;
      batch_done_q  <= batch_done_d;
      err_q         <= err_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_latency  = rsp_latency_q;
  assign rsp_index    = rsp_index_q;
  assign batch_done   = batch_done_q;
  assign err_spurious = err_q;

endmodule : ap_ctrl_initiator

// File: tb/tb_ap_ctrl_initiator.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_initiator
//   Self-checking bench for ap_ctrl_initiator. A transaction-level model
//   (batch bookkeeping plus a queue of start timestamps) predicts every
//   control output each cycle; a small kernel model drives ap_ready/ap_done
//   from the model's predicted ap_start.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_initiator;

  localparam int CNT_W = 16;
  localparam int TS_W  = 32;
  localparam int DEPTH = 4;
`ifdef AP_CTRL_INIT_LAT_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TS_W-1:0]  rsp_latency;
  logic [CNT_W-1:0] rsp_index;
  logic             batch_done;
  logic             err_spurious;

  always #5 ap_clk = ~ap_clk;

  ap_ctrl_initiator #(
    .CNT_W (CNT_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_count    (req_count),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_latency  (rsp_latency),
    .rsp_index    (rsp_index),
    .batch_done   (batch_done),
    .err_spurious (err_spurious)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit              m_run      = 1'b0;
  int              m_left     = 0;
  logic [TS_W-1:0] m_ts[$];
  int              m_done_cnt = 0;
  bit              m_rv       = 1'b0;
  logic [TS_W-1:0] m_lat      = '0;
  int              m_idx      = 0;
  bit              m_bd       = 1'b0;
  bit              m_err      = 1'b0;
  logic [TS_W-1:0] now        = '0;

  // Kernel model: due cycle of each in-flight invocation, in order
  int k_due[$];
  int tick       = 0;
  int k_dly      = 1;
  bit force_done = 1'b0;

  logic [5:0]       e_vec, o_vec;
  logic [CNT_W-1:0] e_idx;
  logic [TS_W-1:0]  e_lat;

  function automatic bit m_start();
    return m_run && (m_left != 0) && (m_ts.size() < DEPTH);
  endfunction

  // Drive the kernel's done for this cycle and compute predictions.
  task automatic settle();
    ap_done = force_done || ((k_due.size() > 0) && (k_due[0] <= tick));
    #1;
    e_vec = {!m_run, m_start(), (!m_rv || rsp_ready), m_rv, m_bd, m_err};
    o_vec = {req_ready, ap_start, ap_continue, rsp_valid, batch_done, err_spurious};
    e_idx = 16'(m_idx);
    e_lat = LAT_EN ? m_lat : '0;
  endtask

  // Apply the rising edge to the model, then move to the next falling edge.
  task automatic advance();
    bit acc, cont, cpl, spur;
    acc  = m_start() && ap_ready;
    cont = !m_rv || rsp_ready;
    cpl  = ap_done && cont && (m_ts.size() > 0);
    spur = ap_done && (m_ts.size() == 0);
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      m_run = 0; m_left = 0; m_ts.delete(); m_done_cnt = 0; m_rv = 0;
      m_lat = '0; m_idx = 0; m_bd = 0; m_err = 0; now = '0; k_due.delete();
    end else begin
      m_bd = 0;
      if (cpl) begin
        m_lat = now - m_ts.pop_front();
        m_idx = m_done_cnt;
        m_done_cnt++;
        m_rv = 1;
        void'(k_due.pop_front());
      end else if (m_rv && rsp_ready) begin
        m_rv = 0;
      end
      if (!m_run) begin
        if (req_valid) begin
          if (req_count == 0) m_bd = 1;
          else begin
            m_run = 1; m_left = int'(req_count); m_done_cnt = 0; m_err = 0;
          end
        end
      end else begin
        if (acc) begin
          m_ts.push_back(now);
          m_left--;
          k_due.push_back(tick + k_dly);
        end
        if ((m_left == 0) && (m_ts.size() == 0)) begin
          m_run = 0;
          m_bd  = 1;
        end
      end
      if (spur) m_err = 1;
      now = now + 1;
    end
    tick++;
    @(negedge ap_clk);
  endtask

  task automatic test_reset();
    ap_rst_n = 0; req_valid = 0; req_count = '0; ap_ready = 0;
    rsp_ready = 1; force_done = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      advance();
    end
    settle();
    n_chk++;
    if (o_vec !== 6'b101000) $display("FAIL reset_ctl got=%b exp=%b", o_vec, 6'b101000);
    else n_pass++;
    n_chk++;
    if ({rsp_index, rsp_latency} !== '0)
      $display("FAIL reset_data got idx=%0d lat=%0d exp 0/0", rsp_index, rsp_latency);
    else n_pass++;
    ap_rst_n = 1;
    advance();
  endtask

  task automatic test_single();
    int nrsp, nbd;
    logic [TS_W-1:0]  got_lat;
    logic [CNT_W-1:0] got_idx;
    nrsp = 0; nbd = 0; got_lat = '1; got_idx = '1;
    k_dly = 10; ap_ready = 1; rsp_ready = 1; req_count = 1;
    for (int i = 0; i < 20; i++) begin
      req_valid = (i == 0);
      settle();
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL single_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      if (rsp_valid) begin
        nrsp++; got_lat = rsp_latency; got_idx = rsp_index;
      end
      if (batch_done) nbd++;
      advance();
    end
    n_chk++;
    if (nrsp !== 1 || got_idx !== 0) $display("FAIL single_rsp got n=%0d idx=%0d exp n=1 idx=0", nrsp, got_idx);
    else n_pass++;
    n_chk++;
    if (got_lat !== (LAT_EN ? 32'd10 : 32'd0))
      $display("FAIL single_lat got=%0d exp=%0d", got_lat, LAT_EN ? 10 : 0);
    else n_pass++;
    n_chk++;
    if (nbd !== 1) $display("FAIL single_batch_done got=%0d pulses exp=1", nbd);
    else n_pass++;
  endtask

  task automatic test_depth();
    int starts, nexp;
    starts = 0; nexp = 0;
    k_dly = 100000; ap_ready = 1; rsp_ready = 1; req_count = 6;
    for (int i = 0; i < 60; i++) begin
      req_valid = (i == 0);
      if (i == 9) k_due[0] = tick;
      if (i == 12) begin
        k_dly = 3;
        foreach (k_due[j]) k_due[j] = tick + j + 1;
      end
      settle();
      if (i == 9) begin
        n_chk++;
        if (starts !== 4 || ap_start !== 1'b0)
          $display("FAIL depth_limit got starts=%0d ap_start=%b exp 4/0", starts, ap_start);
        else n_pass++;
      end
      if (i == 10) begin
        n_chk++;
        if (ap_start !== 1'b1) $display("FAIL depth_restart got ap_start=%b exp=1", ap_start);
        else n_pass++;
      end
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL depth_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      if (ap_start && ap_ready) starts++;
      if (rsp_valid && rsp_ready) begin
        n_chk++;
        if (rsp_index !== 16'(nexp)) $display("FAIL depth_index got=%0d exp=%0d", rsp_index, nexp);
        else n_pass++;
        nexp++;
      end
      advance();
    end
    n_chk++;
    if (nexp !== 6) $display("FAIL depth_count got=%0d responses exp=6", nexp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    k_dly = 2; ap_ready = 1; req_count = 3;
    for (int i = 0; i < 30; i++) begin
      req_valid = (i == 0);
      rsp_ready = (i >= 12);
      settle();
      if (i == 10) begin
        n_chk++;
        if (ap_continue !== 1'b0 || rsp_valid !== 1'b1 || rsp_index !== 0)
          $display("FAIL bp_hold got cont=%b vld=%b idx=%0d exp 0/1/0", ap_continue, rsp_valid, rsp_index);
        else n_pass++;
      end
      if (i == 13) begin
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_index !== 1)
          $display("FAIL bp_release got vld=%b idx=%0d exp 1/1", rsp_valid, rsp_index);
        else n_pass++;
      end
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL bp_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      if (m_rv) begin
        n_chk++;
        if ({rsp_index, rsp_latency} !== {e_idx, e_lat})
          $display("FAIL bp_data got idx=%0d lat=%0d exp idx=%0d lat=%0d", rsp_index, rsp_latency, e_idx, e_lat);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_spurious();
    k_dly = 3; ap_ready = 1; rsp_ready = 1; req_count = 1;
    for (int i = 0; i < 15; i++) begin
      req_valid  = (i == 5);
      force_done = (i == 2);
      settle();
      if (i == 3) begin
        n_chk++;
        if (err_spurious !== 1'b1 || rsp_valid !== 1'b0)
          $display("FAIL spur_set got err=%b vld=%b exp 1/0", err_spurious, rsp_valid);
        else n_pass++;
      end
      if (i == 6) begin
        n_chk++;
        if (err_spurious !== 1'b0) $display("FAIL spur_clear got err=%b exp=0", err_spurious);
        else n_pass++;
      end
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL spur_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      advance();
    end
    force_done = 0;
  endtask

  task automatic test_reset_mid();
    int nbd;
    nbd = 0;
    k_dly = 100000; ap_ready = 1; rsp_ready = 1;
    for (int i = 0; i < 30; i++) begin
      req_valid = (i == 0) || (i == 6);
      req_count = (i < 6) ? 16'd5 : 16'd2;
      if (i == 4) begin ap_rst_n = 0; ap_ready = 0; end
      if (i == 5) ap_rst_n = 1;
      if (i == 6) begin ap_ready = 1; k_dly = 4; end
      settle();
      if (i == 5) begin
        n_chk++;
        if (ap_start !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0)
          $display("FAIL rstmid_state got start=%b rdy=%b vld=%b exp 0/1/0", ap_start, req_ready, rsp_valid);
        else n_pass++;
      end
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL rstmid_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      if (m_rv) begin
        n_chk++;
        if ({rsp_index, rsp_latency} !== {e_idx, e_lat})
          $display("FAIL rstmid_data got idx=%0d lat=%0d exp idx=%0d lat=%0d", rsp_index, rsp_latency, e_idx, e_lat);
        else n_pass++;
      end
      if (batch_done) nbd++;
      advance();
    end
    n_chk++;
    if (nbd !== 1) $display("FAIL rstmid_batch got=%0d pulses exp=1", nbd);
    else n_pass++;
  endtask

  task automatic test_zero();
    int nstart;
    nstart = 0;
    ap_ready = 1; rsp_ready = 1; req_count = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = (i == 1);
      settle();
      if (i == 2) begin
        n_chk++;
        if (batch_done !== 1'b1) $display("FAIL zero_batch got=%b exp=1", batch_done);
        else n_pass++;
      end
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL zero_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      if (ap_start) nstart++;
      advance();
    end
    n_chk++;
    if (nstart !== 0) $display("FAIL zero_start got=%0d start cycles exp=0", nstart);
    else n_pass++;
  endtask

`ifdef AP_CTRL_INIT_LAT_EN
  task automatic test_wrap();
    logic [TS_W-1:0] got_lat;
    got_lat = '0;
    dut.cyc_q = 32'hFFFF_FFFD;
    k_dly = 5; ap_ready = 1; rsp_ready = 1; req_count = 1;
    for (int i = 0; i < 15; i++) begin
      req_valid = (i == 0);
      settle();
      if (rsp_valid) got_lat = rsp_latency;
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL wrap_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      advance();
    end
    n_chk++;
    if (got_lat !== 32'd5) $display("FAIL wrap_lat got=%0d exp=5", got_lat);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    int nb, guard;
    nb = 0; guard = 0;
    while (!((nb == 8) && !m_run && !m_rv) && (guard < 3000)) begin
      if (!m_run && !req_valid && (nb < 8) && ($urandom_range(0, 2) == 0)) begin
        req_valid = 1; req_count = 16'($urandom_range(0, 12)); nb++;
      end else if (m_run && ($urandom_range(0, 7) == 0)) begin
        req_valid = 1; req_count = 16'($urandom_range(0, 12));
      end else begin
        req_valid = 0;
      end
      ap_ready   = ($urandom_range(0, 1) == 1);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      k_dly      = $urandom_range(1, 6);
      force_done = (m_ts.size() == 0) && ($urandom_range(0, 19) == 0);
      settle();
      n_chk++;
      if (o_vec !== e_vec) $display("FAIL rand_ctl t=%0d got=%b exp=%b", tick, o_vec, e_vec);
      else n_pass++;
      if (m_rv) begin
        n_chk++;
        if ({rsp_index, rsp_latency} !== {e_idx, e_lat})
          $display("FAIL rand_data got idx=%0d lat=%0d exp idx=%0d lat=%0d", rsp_index, rsp_latency, e_idx, e_lat);
        else n_pass++;
      end
      advance();
      guard++;
    end
    force_done = 0; req_valid = 0;
    n_chk++;
    if (guard >= 3000) $display("FAIL rand_timeout got %0d cycles exp completion", guard);
    else n_pass++;
  endtask

  initial begin
    ap_done = 0;
    @(negedge ap_clk);
    test_reset();
    test_single();
    test_depth();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    test_zero();
`ifdef AP_CTRL_INIT_LAT_EN
    test_wrap();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ap_ctrl_initiator

// File: doc/ap_ctrl_initiator.md
# ap_ctrl_initiator

- Synthesizable initiator (master) side of the `ap_ctrl_hs` / `ap_ctrl_chain` block-level handshake.
- Accepts a batch request, drives `ap_start` for the requested number of invocations, and keeps up to DEPTH invocations in flight.
- Consumes each `ap_done` and returns one response per invocation, carrying the measured start-to-done latency.
- Sits between the accelerator's control/DMA logic and an HLS kernel top (e.g. `example`).

## Interface
- CNT_W, 16: width of batch count and response index.
- TS_W, 32: width of free-running cycle counter and latency.
- DEPTH, 4: maximum outstanding invocations; power of 2, ≥2.
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  batch request valid.
- req_ready  out  1  high only in IDLE.
- req_count  in  CNT_W  invocations in the batch.
- ap_start  out  1  kernel start.
- ap_ready  in  1  kernel accepted the start.
- ap_done  in  1  kernel completed one invocation.
- ap_continue  out  1  completion consumed (chain mode; harmless for hs).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response sink ready.
- rsp_latency  out  TS_W  cycles from start acceptance to done.
- rsp_index  out  CNT_W  invocation number within the batch, from 0.
- batch_done  out  1  one-cycle pulse when the batch completes.
- err_spurious  out  1  sticky flag: `ap_done` seen with nothing outstanding.

## Operation
- States: IDLE and RUN.
- IDLE:
  - `req_valid` high with `req_count` ≠ 0 → latch `starts_left = req_count`; clear `done_cnt` and `err_spurious`; go to RUN.
  - `req_valid` high with `req_count` = 0 → accept the request, pulse `batch_done` the next cycle, stay in IDLE.
- Start and done logic (RUN):
  - `ap_start = RUN && starts_left ≠ 0 && outstanding < DEPTH`. Decoded from registers only.
  - Start accepted when `ap_start && ap_ready`: decrement `starts_left`, increment `outstanding`, push the current `cyc` value into the timestamp FIFO.
  - `ap_continue = !rsp_valid || rsp_ready`.
  - Completion when `ap_done && ap_continue && outstanding_q ≠ 0`: pop the FIFO; on the next edge load `rsp_latency = cyc − ts_pop` (mod 2^TS_W) and `rsp_index = done_cnt`; set `rsp_valid`; increment `done_cnt`; decrement `outstanding`.
- Simultaneous start accept and completion: FIFO push and pop in the same cycle; `outstanding` unchanged.
- Batch end: `starts_left = 0` and `outstanding = 0` after the update → pulse `batch_done`, go to IDLE. The last response may still be pending, and a new request is accepted regardless.
- `rsp_valid` clears on `rsp_valid && rsp_ready` unless a new completion loads the same cycle.
- Spurious done: `ap_done` while `outstanding_q = 0` (including in IDLE) sets `err_spurious`; no response and no FIFO pop. This also applies when a start is accepted in the same cycle.
- `cyc`: free-running TS_W counter, wraps silently.

## Timing
- Reset values: `req_ready` 1, `ap_start` 0, `ap_continue` 1, `rsp_valid` 0, `rsp_latency` 0, `rsp_index` 0, `batch_done` 0, `err_spurious` 0.
- Internal reset values: state IDLE, counters 0, FIFO empty.
- Reset mid-batch: at the reset edge `ap_start` falls and in-flight invocations are abandoned. The kernel is reset by the same `ap_rst_n`.
- Request accepted at edge N → `ap_start` high from cycle N+1.
- Response appears one cycle after the completing `ap_done` cycle.
- `ap_continue` has a combinational path from `rsp_ready`. All other outputs are registered or register-decoded.
- Sustained throughput: one start and one completion per cycle.

## Configuration
- Macro `AP_CTRL_INIT_LAT_EN`.
- Defined: timestamp FIFO and `cyc` counter are built; `rsp_latency` is as specified.
- Undefined: FIFO and `cyc` are omitted and `rsp_latency` is tied to 0. The `outstanding` counter, DEPTH limit and all handshakes are unchanged.

## Structure
- Package `ap_ctrl_init_pkg` holds:
  - state enum (IDLE, RUN);
  - `ts_t` (`logic [TS_W-1:0]`);
  - default width constants.
- Sub-module `ap_ctrl_ts_fifo`:
  - DEPTH × TS_W;
  - same-cycle push/pop;
  - synchronous active-low reset of pointers only.

## Test plan
- req_count=1; kernel raises `ap_ready` on the first `ap_start` cycle and `ap_done` 10 cycles later → `rsp_latency`=10, `rsp_index`=0, `batch_done` pulses once.
- req_count=6, DEPTH=4, kernel never signals done → exactly 4 starts accepted and `ap_start` low. First `ap_done` → `ap_start` reasserts next cycle. All 6 responses carry `rsp_index` 0–5 in order.
- `rsp_ready` held 0 with a response pending, kernel holds `ap_done` (chain) → `ap_continue`=0 and no second response. Raise `rsp_ready` → the held done is consumed the same cycle and the next response appears one cycle later.
- `ap_done` pulsed in IDLE → `err_spurious`=1, `rsp_valid` stays 0. Next accepted request clears the flag.
- Reset asserted with 3 invocations outstanding → next cycle `ap_start`=0, `req_ready`=1, `rsp_valid`=0, and a new batch runs normally.
- req_count=0 → `batch_done` pulses the next cycle and `ap_start` never rises. With `cyc` forced near wrap, latency 5 across the wrap → `rsp_latency`=5.
